phase_sequencer: RTL and testbench



---
 rtl/phase_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_phase_sequencer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// -----------------------------------------------------------------------------
// phase_sequencer
// Run controller for the 16-bit multi-cycle core. Produces the instruction
// phase (0 idle, 1..5 execute) and the PC-advance strobe. It handles run/stop
// and single-step from the raw board buttons, and it stops on HLT and on an
// address breakpoint. Masked phases stall while memory is busy.
//
// Ports
//   clk             system clock
//   rst_n           synchronous active-low reset
//   exec_n_i        raw run/stop button, active-low, asynchronous
//   step_n_i        raw single-step button, active-low, asynchronous
//   hlt_i           halt decode from control unit (level)
//   mem_busy_i      memory not ready; holds phases selected by STALL_MASK
//   pc_i            current PC, compared against bp_addr_i
//   bp_addr_i       breakpoint address
//   bp_en_i         breakpoint enable
//   phase_o         current phase 0..5
//   pc_e_o          PC advance strobe, high exactly during phase 5
//   running_o       phase_o != 0
//   halted_o        last stop was caused by hlt
//   stop_reason_o   00 none, 01 exec, 10 hlt, 11 breakpoint
//   instr_count_o   retired instruction count (wraps)
// -----------------------------------------------------------------------------
module phase_sequencer #(
  parameter int         CNT_W      = 16,
  parameter logic [4:0] STALL_MASK = 5'b01001
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             exec_n_i,
  input  logic             step_n_i,
  input  logic             hlt_i,
  input  logic             mem_busy_i,
  input  logic [15:0]      pc_i,
  input  logic [15:0]      bp_addr_i,
  input  logic             bp_en_i,
  output logic [2:0]       phase_o,
  output logic             pc_e_o,
  output logic             running_o,
  output logic             halted_o,
  output logic [1:0]       stop_reason_o,
  output logic [CNT_W-1:0] instr_count_o
);

  typedef enum logic [2:0] {
    PH_IDLE = 3'd0,
    PH_1    = 3'd1,
    PH_2    = 3'd2,
    PH_3    = 3'd3,
    PH_4    = 3'd4,
    PH_5    = 3'd5
  } phase_e;

  phase_e           phase_q;
  logic             pc_e_q;
  logic             halted_q;
  logic [1:0]       stop_reason_q;
  logic [CNT_W-1:0] instr_count_q;
  logic             stop_pending_q;
  logic             hlt_pending_q;   // a pending stop includes a sampled hlt
  logic             step_mode_q;

  // Two synchronizer flops per button plus one delay flop for edge detection
  logic exec_s1_q, exec_s2_q, exec_prev_q;
  logic step_s1_q, step_s2_q, step_prev_q;

  logic       exec_ev_s;
  logic       step_ev_s;
  logic       bp_hit_s;
  logic       stall_s;
  logic       stop_now_s;
  logic [1:0] exit_reason_s;

  // Press event: synced level falls from 1 to 0
  assign exec_ev_s = exec_prev_q & ~exec_s2_q;
  assign step_ev_s = step_prev_q & ~step_s2_q;

  assign bp_hit_s   = bp_en_i & (pc_i == bp_addr_i);
  // hlt is also checked live so a halt decoded in phase 5 itself stops
  assign stop_now_s = stop_pending_q | exec_ev_s | hlt_i | bp_hit_s | step_mode_q;

  // Stall decision for the current phase; idle and phase 5 never stall
  always_comb begin
    stall_s = 1'b0;
    case (phase_q)
      PH_1:    stall_s = mem_busy_i & STALL_MASK[0];
      PH_2:    stall_s = mem_busy_i & STALL_MASK[1];
      PH_3:    stall_s = mem_busy_i & STALL_MASK[2];
      PH_4:    stall_s = mem_busy_i & STALL_MASK[3];
      default: stall_s = 1'b0;
    endcase
  end

  // Stop reason at the exit edge: hlt > breakpoint > exec; a bare step gives 00
  always_comb begin
    exit_reason_s = 2'b00;
    if (hlt_pending_q | hlt_i) begin
      exit_reason_s = 2'b10;
    end else if (bp_hit_s) begin
      exit_reason_s = 2'b11;
    end else if (stop_pending_q | exec_ev_s) begin
      exit_reason_s = 2'b01;
    end else begin
      exit_reason_s = 2'b00;
    end
  end

  // Button synchronizers, phase FSM and registered status outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exec_s1_q      <= 1'b1;
      exec_s2_q      <= 1'b1;
      exec_prev_q    <= 1'b1;
      step_s1_q      <= 1'b1;
      step_s2_q      <= 1'b1;
      step_prev_q    <= 1'b1;
      phase_q        <= PH_IDLE;
      pc_e_q         <= 1'b0;
      halted_q       <= 1'b0;
      stop_reason_q  <= 2'b00;
      instr_count_q  <= '0;
      stop_pending_q <= 1'b0;
      hlt_pending_q  <= 1'b0;
      step_mode_q    <= 1'b0;
    end else begin
      exec_s1_q   <= exec_n_i;
      exec_s2_q   <= exec_s1_q;
      exec_prev_q <= exec_s2_q;
      step_s1_q   <= step_n_i;
      step_s2_q   <= step_s1_q;
      step_prev_q <= step_s2_q;
      pc_e_q      <= 1'b0;

      case (phase_q)
        PH_IDLE: begin
          if (exec_ev_s) begin
            phase_q       <= PH_1;
            step_mode_q   <= 1'b0;
            halted_q      <= 1'b0;
            stop_reason_q <= 2'b00;
          end else if (step_ev_s) begin
            phase_q       <= PH_1;
            step_mode_q   <= 1'b1;
            halted_q      <= 1'b0;
            stop_reason_q <= 2'b00;
          end else begin
            phase_q <= PH_IDLE;
          end
        end
        PH_1, PH_2, PH_3, PH_4: begin
          if (exec_ev_s | hlt_i) begin
            stop_pending_q <= 1'b1;
          end
          if (hlt_i) begin
            hlt_pending_q <= 1'b1;
          end
          if (!stall_s) begin
            phase_q <= phase_e'(phase_q + 3'd1);
            // Strobe is registered so it is high for exactly the phase-5 cycle
            pc_e_q  <= (phase_q == PH_4);
          end
        end
        PH_5: begin
          instr_count_q <= instr_count_q + CNT_W'(1);
          if (stop_now_s) begin
            phase_q        <= PH_IDLE;
            stop_pending_q <= 1'b0;
            hlt_pending_q  <= 1'b0;
            step_mode_q    <= 1'b0;
            stop_reason_q  <= exit_reason_s;
            halted_q       <= (exit_reason_s == 2'b10);
          end else begin
            phase_q <= PH_1;
          end
        end
        default: begin
          phase_q <= PH_IDLE;
        end
      endcase
    end
  end

  assign phase_o       = phase_q;
  assign pc_e_o        = pc_e_q;
  assign running_o     = (phase_q != PH_IDLE);
  assign halted_o      = halted_q;
  assign stop_reason_o = stop_reason_q;
  assign instr_count_o = instr_count_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_phase_sequencer
// Directed bench for phase_sequencer. A second instance with a 3-bit counter
// shares the same stimulus so that counter wrap is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_phase_sequencer;

  logic        clk;
  logic        rst_n;
  logic        exec_n;
  logic        step_n;
  logic        hlt;
  logic        mem_busy;
  logic [15:0] pc;
  logic [15:0] bp_addr;
  logic        bp_en;

  logic [2:0]  phase;
  logic        pc_e;
  logic        running;
  logic        halted;
  logic [1:0]  stop_reason;
  logic [15:0] instr_count;

  logic [2:0]  sm_phase;
  logic        sm_pc_e;
  logic        sm_running;
  logic        sm_halted;
  logic [1:0]  sm_stop_reason;
  logic [2:0]  sm_instr_count;

  int n_cmp;
  int n_bad;

  phase_sequencer dut (
    .clk(clk), .rst_n(rst_n), .exec_n_i(exec_n), .step_n_i(step_n),
    .hlt_i(hlt), .mem_busy_i(mem_busy), .pc_i(pc), .bp_addr_i(bp_addr),
    .bp_en_i(bp_en), .phase_o(phase), .pc_e_o(pc_e), .running_o(running),
    .halted_o(halted), .stop_reason_o(stop_reason), .instr_count_o(instr_count)
  );

  phase_sequencer #(.CNT_W(3)) dut_small (
    .clk(clk), .rst_n(rst_n), .exec_n_i(exec_n), .step_n_i(step_n),
    .hlt_i(hlt), .mem_busy_i(mem_busy), .pc_i(pc), .bp_addr_i(bp_addr),
    .bp_en_i(bp_en), .phase_o(sm_phase), .pc_e_o(sm_pc_e), .running_o(sm_running),
    .halted_o(sm_halted), .stop_reason_o(sm_stop_reason), .instr_count_o(sm_instr_count)
  );

  // 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_phase(input string tag, input logic [2:0] exp_ph);
    check_eq(tag, 32'(phase), 32'(exp_ph));
  endtask

  // Hold the selected buttons low for one clock, then release
  task automatic press(input logic do_exec, input logic do_step);
    exec_n = ~do_exec;
    step_n = ~do_step;
    tick();
    exec_n = 1'b1;
    step_n = 1'b1;
  endtask

  logic [2:0] run_ph [5];
  logic       run_pe [5];

  initial begin
    n_cmp    = 0;
    n_bad    = 0;
    rst_n    = 1'b0;
    exec_n   = 1'b1;
    step_n   = 1'b1;
    hlt      = 1'b0;
    mem_busy = 1'b0;
    pc       = 16'h0000;
    bp_addr  = 16'h0000;
    bp_en    = 1'b0;
    run_ph   = '{3'd2, 3'd3, 3'd4, 3'd5, 3'd1};
    run_pe   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    // Reset values
    ticks(2);
    check_phase("rst_phase", 3'd0);
    check_eq("rst_pc_e", 32'(pc_e), 32'd0);
    check_eq("rst_running", 32'(running), 32'd0);
    check_eq("rst_halted", 32'(halted), 32'd0);
    check_eq("rst_reason", 32'(stop_reason), 32'd0);
    check_eq("rst_count", 32'(instr_count), 32'd0);

    // Exec held 3 cycles: acted on two edges after first sampled low, once
    rst_n  = 1'b1;
    exec_n = 1'b0;
    tick();
    check_phase("sync_e1", 3'd0);
    tick();
    check_phase("sync_e2", 3'd0);
    tick();
    check_phase("start_ph1", 3'd1);
    check_eq("start_running", 32'(running), 32'd1);
    exec_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_phase("run_seq", run_ph[i]);
      check_eq("run_pc_e", 32'(pc_e), 32'(run_pe[i]));
    end
    check_eq("run_count1", 32'(instr_count), 32'd1);

    // hlt in phase 3 of instruction 4
    ticks(12);
    check_phase("hlt_pre_ph", 3'd3);
    check_eq("hlt_pre_count", 32'(instr_count), 32'd3);
    hlt = 1'b1;
    tick();
    check_phase("hlt_ph4", 3'd4);
    hlt = 1'b0;
    tick();
    check_phase("hlt_ph5", 3'd5);
    check_eq("hlt_pc_e", 32'(pc_e), 32'd1);
    tick();
    check_phase("hlt_stop", 3'd0);
    check_eq("hlt_running", 32'(running), 32'd0);
    check_eq("hlt_halted", 32'(halted), 32'd1);
    check_eq("hlt_reason", 32'(stop_reason), 32'd2);
    check_eq("hlt_count", 32'(instr_count), 32'd4);
    ticks(2);
    check_phase("hlt_idle", 3'd0);

    // Two single steps
    for (int s = 0; s < 2; s++) begin
      press(1'b0, 1'b1);
      check_phase("step_wait0", 3'd0);
      tick();
      check_phase("step_wait1", 3'd0);
      tick();
      check_phase("step_ph1", 3'd1);
      check_eq("step_halted_clr", 32'(halted), 32'd0);
      check_eq("step_reason_clr", 32'(stop_reason), 32'd0);
      ticks(4);
      check_phase("step_ph5", 3'd5);
      tick();
      check_phase("step_end", 3'd0);
      check_eq("step_reason", 32'(stop_reason), 32'd0);
      check_eq("step_count", 32'(instr_count), 32'(5 + s));
      ticks(2);
      check_phase("step_stay_idle", 3'd0);
    end

    // Breakpoint at 0x0007
    bp_en   = 1'b1;
    bp_addr = 16'h0007;
    pc      = 16'h0005;
    press(1'b1, 1'b0);
    ticks(2);
    check_phase("bp_start", 3'd1);
    ticks(5);
    check_phase("bp_miss_cont", 3'd1);
    check_eq("bp_miss_count", 32'(instr_count), 32'd7);
    pc = 16'h0007;
    ticks(5);
    check_phase("bp_stop", 3'd0);
    check_eq("bp_reason", 32'(stop_reason), 32'd3);
    check_eq("bp_halted", 32'(halted), 32'd0);
    check_eq("bp_count", 32'(instr_count), 32'd8);
    bp_en = 1'b0;
    press(1'b1, 1'b0);
    ticks(2);
    check_phase("bp_resume", 3'd1);
    check_eq("bp_resume_reason", 32'(stop_reason), 32'd0);

    // Exec press while running: instruction completes, then stops
    exec_n = 1'b0;
    tick();
    check_phase("xstop_ph2", 3'd2);
    exec_n = 1'b1;
    ticks(3);
    check_phase("xstop_ph5", 3'd5);
    tick();
    check_phase("xstop_end", 3'd0);
    check_eq("xstop_reason", 32'(stop_reason), 32'd1);
    check_eq("xstop_count", 32'(instr_count), 32'd9);

    // Exec+step together (exec wins, continuous run) with memory stalls
    press(1'b1, 1'b1);
    mem_busy = 1'b1;
    tick();
    check_phase("stall_wait", 3'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_phase("stall_ph1_hold", 3'd1);
    end
    mem_busy = 1'b0;
    tick();
    check_phase("stall_ph2", 3'd2);
    mem_busy = 1'b1;
    tick();
    check_phase("nostall_ph3", 3'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_phase("stall_ph4_hold", 3'd4);
      check_eq("stall_pc_e_low", 32'(pc_e), 32'd0);
    end
    mem_busy = 1'b0;
    tick();
    check_phase("stall_ph5", 3'd5);
    check_eq("stall_pc_e", 32'(pc_e), 32'd1);
    mem_busy = 1'b1;
    tick();
    check_phase("ph5_no_stall", 3'd1);
    check_eq("both_exec_wins_count", 32'(instr_count), 32'd10);
    tick();
    check_phase("stall_again_ph1", 3'd1);
    mem_busy = 1'b0;

    // Reset mid-instruction
    ticks(2);
    check_phase("pre_rst_ph3", 3'd3);
    rst_n = 1'b0;
    tick();
    check_phase("mid_rst_phase", 3'd0);
    check_eq("mid_rst_pc_e", 32'(pc_e), 32'd0);
    check_eq("mid_rst_running", 32'(running), 32'd0);
    check_eq("mid_rst_halted", 32'(halted), 32'd0);
    check_eq("mid_rst_reason", 32'(stop_reason), 32'd0);
    check_eq("mid_rst_count", 32'(instr_count), 32'd0);
    check_eq("mid_rst_sm_count", 32'(sm_instr_count), 32'd0);
    check_eq("mid_rst_sm_flags", 32'({sm_pc_e, sm_halted, sm_stop_reason}), 32'd0);
    rst_n = 1'b1;
    tick();
    check_phase("post_rst_idle", 3'd0);

    // Counter wrap on the 3-bit instance
    press(1'b1, 1'b0);
    ticks(2);
    check_phase("wrap_start", 3'd1);
    ticks(35);
    check_eq("wrap_pre_big", 32'(instr_count), 32'd7);
    check_eq("wrap_pre_small", 32'(sm_instr_count), 32'd7);
    ticks(5);
    check_eq("wrap_big", 32'(instr_count), 32'd8);
    check_eq("wrap_small", 32'(sm_instr_count), 32'd0);
    check_eq("wrap_sm_phase", 32'(sm_phase), 32'd1);
    check_eq("wrap_sm_running", 32'(sm_running), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
